// File: rtl/row_fill_sequencer.sv
// Row-fill sequencer for the three-row conv shift-register window.
// Walks output rows and column segments of one tile, issuing 32-pixel fill reads and shift-phase pulses.
module row_fill_sequencer #(
    parameter int SHIFT_REGS_NUM = 70,
    parameter int PIXELS_IN_ROW  = 32,
    parameter int SEG_CAP        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  k,
    input  logic [3:0]  s,
    input  logic [3:0]  pad,
    input  logic [15:0] in_width,
    input  logic [15:0] in_height,
    output logic        rd_req,
    input  logic        rd_ack,
    output logic [15:0] rd_col,
    output logic [15:0] row1_idx,
    output logic [15:0] row2_idx,
    output logic [15:0] row3_idx,
    output logic [2:0]  row_valid,
    output logic [3:0]  west_pad,
    output logic [3:0]  slab_num,
    output logic [3:0]  east_pad,
    output logic [15:0] reg_start_idx,
    output logic [15:0] reg_end_idx,
    output logic        fill_en,
    output logic        conv_min_pixels_add_end,
    output logic        conv_pixels_add_end,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    // state | meaning
    // IDLE  | waiting for start
    // ROW   | one cycle: new output row, reset column walk
    // FILL  | issuing one or two 32-pixel reads for the segment
    // SHIFT | k-cycle shift/accumulate phase
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_FILL, S_SHIFT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_k, r_s, r_pad, r_cnt;
    logic [15:0] r_w, r_h, r_col;
    logic [16:0] r_base;
    logic [7:0]  r_seg;
    logic        r_rd, r_cfg_err;

    logic [16:0] w_hsum_in, w_hsum;
    logic        w_cfg_bad, w_more_rows, w_last, w_two, w_shift_last, w_active, w_k1;
    logic [15:0] w_rem, w_p, w_n0, w_start0, w_end0, w_start1, w_end1, w_rd_col;
    logic [15:0] w_row1, w_row2, w_row3;
    logic [3:0]  w_west, w_slab, w_east;

    // Output-row bound checked incrementally as (oy+1)*s + k <= H + 2*pad, avoiding a divider.
    assign w_hsum_in   = {1'b0, in_height} + {12'b0, pad, 1'b0};
    assign w_cfg_bad   = (k != 4'd1 && k != 4'd3) || (s == 4'd0) || (in_width == 16'd0) ||
                         (in_height == 16'd0) || (pad > 4'd1) || (w_hsum_in < {13'b0, k});
    assign w_hsum      = {1'b0, r_h} + {12'b0, r_pad, 1'b0};
    assign w_more_rows = (r_base + {13'b0, r_s} + {13'b0, r_k}) <= w_hsum;

    assign w_rem    = r_w - r_col;
    assign w_last   = w_rem <= 16'(SEG_CAP);
    assign w_p      = w_last ? w_rem : 16'(SEG_CAP);
    assign w_two    = w_p > 16'(PIXELS_IN_ROW);
    assign w_west   = (r_seg == 8'd0) ? r_pad : 4'd0;
    assign w_slab   = (r_seg == 8'd0) ? 4'd0 : r_k - 4'd1;
    assign w_east   = w_last ? r_pad : 4'd0;
    assign w_n0     = w_two ? 16'(PIXELS_IN_ROW) : w_p;
    assign w_start0 = 16'd1 + {12'b0, w_west} + {12'b0, w_slab};
    assign w_end0   = w_start0 + w_n0 - 16'd1;
    assign w_start1 = w_end0 + 16'd1;
    assign w_end1   = w_start1 + w_p - 16'(PIXELS_IN_ROW) - 16'd1;
    assign w_rd_col = r_rd ? r_col + 16'(PIXELS_IN_ROW) : r_col;

    assign w_row1 = r_base[15:0] - {12'b0, r_pad};
    assign w_row2 = w_row1 + 16'd1;
    assign w_row3 = w_row1 + 16'd2;
    assign w_k1   = (r_k == 4'd1);

    assign w_shift_last = (r_cnt == r_k - 4'd1);
    assign w_active     = (r_state == S_ROW) || (r_state == S_FILL) || (r_state == S_SHIFT);

    assign rd_col        = w_active ? w_rd_col : 16'd0;
    assign row1_idx      = w_active ? w_row1 : 16'd0;
    assign row2_idx      = w_active ? w_row2 : 16'd0;
    assign row3_idx      = w_active ? w_row3 : 16'd0;
    assign row_valid     = w_active ? {(w_row3 < r_h) & ~w_k1, (w_row2 < r_h) & ~w_k1, w_row1 < r_h} : 3'b000;
    assign west_pad      = w_active ? w_west : 4'd0;
    assign slab_num      = w_active ? w_slab : 4'd0;
    assign east_pad      = w_active ? w_east : 4'd0;
    assign reg_start_idx = w_active ? (r_rd ? w_start1 : w_start0) : 16'd0;
    assign reg_end_idx   = w_active ? (r_rd ? w_end1 : w_end0) : 16'd0;
    assign fill_en       = rd_req & rd_ack;
    assign cfg_err       = r_cfg_err;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next                  = r_state;
        rd_req                  = 1'b0;
        busy                    = 1'b0;
        done                    = 1'b0;
        conv_min_pixels_add_end = 1'b0;
        conv_pixels_add_end     = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !w_cfg_bad) w_next = S_ROW;
            S_ROW: begin
                busy   = 1'b1;
                w_next = S_FILL;
            end
            S_FILL: begin
                busy   = 1'b1;
                rd_req = 1'b1;
                if (rd_ack && (r_rd || !w_two)) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy                    = 1'b1;
                conv_min_pixels_add_end = (r_cnt == 4'd0);
                conv_pixels_add_end     = w_shift_last;
                if (w_shift_last) begin
                    if (!w_last)         w_next = S_FILL;
                    else if (w_more_rows) w_next = S_ROW;
                    else                 w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k <= '0; r_s <= '0; r_pad <= '0; r_w <= '0; r_h <= '0;
            r_base <= '0; r_col <= '0; r_seg <= '0; r_rd <= 1'b0; r_cnt <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_k       <= k;
                    r_s       <= s;
                    r_pad     <= pad;
                    r_w       <= in_width;
                    r_h       <= in_height;
                    r_base    <= '0;
                    r_cfg_err <= w_cfg_bad;
                end
                S_ROW: begin
                    r_col <= '0;
                    r_seg <= '0;
                    r_rd  <= 1'b0;
                end
                S_FILL: if (rd_ack) begin
                    if (!r_rd && w_two) r_rd  <= 1'b1;
                    else                r_cnt <= '0;
                end
                S_SHIFT: begin
                    if (w_shift_last) begin
                        // Next segment overlaps the previous by k-1 columns so the kernel sees them again.
                        if (!w_last) begin
                            r_col <= r_col + w_p - {12'b0, r_k} + 16'd1;
                            r_seg <= r_seg + 8'd1;
                            r_rd  <= 1'b0;
                        end else if (w_more_rows) begin
                            r_base <= r_base + {13'b0, r_s};
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_window_fits: assert property (@(posedge clk) disable iff (reset)
        rd_req |-> (32'(reg_end_idx) + 32'(east_pad) <= SHIFT_REGS_NUM));

endmodule

// File: tb/tb_row_fill_sequencer.sv
// Scoreboard bench for row_fill_sequencer: directed tiles push expected fill/pulse events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_row_fill_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, rd_ack;
    logic [3:0]  k, s, pad;
    logic [15:0] in_width, in_height;
    logic        rd_req, fill_en, conv_min_pixels_add_end, conv_pixels_add_end, busy, done, cfg_err;
    logic [15:0] rd_col, row1_idx, row2_idx, row3_idx, reg_start_idx, reg_end_idx;
    logic [2:0]  row_valid;
    logic [3:0]  west_pad, slab_num, east_pad;

    row_fill_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .s(s), .pad(pad),
        .in_width(in_width), .in_height(in_height), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_col(rd_col), .row1_idx(row1_idx), .row2_idx(row2_idx), .row3_idx(row3_idx),
        .row_valid(row_valid), .west_pad(west_pad), .slab_num(slab_num), .east_pad(east_pad),
        .reg_start_idx(reg_start_idx), .reg_end_idx(reg_end_idx), .fill_en(fill_en),
        .conv_min_pixels_add_end(conv_min_pixels_add_end),
        .conv_pixels_add_end(conv_pixels_add_end), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 fill, 1 shift start, 2 shift end, 3 done
        logic [15:0] col, st, en, r1;
        logic [3:0]  w, sl, e;
        logic [2:0]  rv;
        int          dly;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, min_cyc = 0;
    int  ack_mode = 0;

    task automatic push_fill(input logic [15:0] col, st, en, input logic [3:0] w, sl, e,
                             input logic [15:0] r1, input logic [2:0] rv);
        ev_t x;
        x.kind = 0; x.col = col; x.st = st; x.en = en; x.w = w; x.sl = sl; x.e = e;
        x.r1 = r1; x.rv = rv; x.dly = 0;
        q.push_back(x);
    endtask

    task automatic push_kind(input int kind, input int dly);
        ev_t x;
        x.kind = kind; x.col = '0; x.st = '0; x.en = '0; x.w = '0; x.sl = '0; x.e = '0;
        x.r1 = '0; x.rv = '0; x.dly = dly;
        q.push_back(x);
    endtask

    task automatic push_shift(input int dly);
        push_kind(1, 0);
        push_kind(2, dly);
    endtask

    task automatic check_ev(input int kind);
        ev_t x;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
            return;
        end
        x = q.pop_front();
        if (x.kind != kind) begin
            n_fail++;
            $display("FAIL event_order: got kind %0d, expected kind %0d", kind, x.kind);
        end else if (kind == 0) begin
            if ({rd_col, reg_start_idx, reg_end_idx, west_pad, slab_num, east_pad, row1_idx,
                 row2_idx, row3_idx, row_valid} !=
                {x.col, x.st, x.en, x.w, x.sl, x.e, x.r1, x.r1 + 16'd1, x.r1 + 16'd2, x.rv}) begin
                n_fail++;
                $display("FAIL fill_geom: got col=%h st=%0d en=%0d w=%0d sl=%0d e=%0d r=%h/%h/%h rv=%b, expected col=%h st=%0d en=%0d w=%0d sl=%0d e=%0d r1=%h rv=%b",
                         rd_col, reg_start_idx, reg_end_idx, west_pad, slab_num, east_pad,
                         row1_idx, row2_idx, row3_idx, row_valid,
                         x.col, x.st, x.en, x.w, x.sl, x.e, x.r1, x.rv);
            end
        end else if (kind == 1) begin
            min_cyc = cyc;
        end else if (kind == 2) begin
            if (cyc - min_cyc != x.dly) begin
                n_fail++;
                $display("FAIL shift_len: got %0d cycles after start pulse, expected %0d", cyc - min_cyc, x.dly);
            end
        end else begin
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_at_done: got %b, expected 0", busy);
            end
        end
    endtask

    logic        p_req = 1'b0, p_ack = 1'b0;
    logic [47:0] p_geo = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (fill_en)                 check_ev(0);
            if (conv_min_pixels_add_end) check_ev(1);
            if (conv_pixels_add_end)     check_ev(2);
            if (done)                    check_ev(3);
            if (ack_mode != 0 && rd_req && p_req && !p_ack) begin
                n_chk++;
                if ({rd_col, reg_start_idx, reg_end_idx} != p_geo) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h, expected %h", {rd_col, reg_start_idx, reg_end_idx}, p_geo);
                end
            end
        end
        p_req = rd_req;
        p_ack = rd_ack;
        p_geo = {rd_col, reg_start_idx, reg_end_idx};
    end

    // Buffer model: ack tied high, or ack after five requesting cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        rd_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) begin
                rd_ack = 1'b1; wcnt = 0;
            end else if (rd_ack) begin
                rd_ack = 1'b0; wcnt = 0;
            end else if (rd_req) begin
                wcnt++;
                if (wcnt >= 5) rd_ack = 1'b1;
            end
        end
    end

    task automatic pulse_start(input logic [3:0] kk, ss, pp, input logic [15:0] ww, hh);
        @(negedge clk);
        k = kk; s = ss; pad = pp; in_width = ww; in_height = hh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL events_left: got %0d pending, expected 0", q.size());
        end
        q.delete();
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({busy, done, rd_req, fill_en, conv_min_pixels_add_end, conv_pixels_add_end, row_valid,
             row1_idx, row2_idx, row3_idx, rd_col, reg_start_idx, reg_end_idx, west_pad, slab_num,
             east_pad, cfg_err} != '0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b rd_req=%b r1=%h rv=%b col=%h st=%0d en=%0d cfg_err=%b, expected all 0",
                     name, busy, rd_req, row1_idx, row_valid, rd_col, reg_start_idx, reg_end_idx, cfg_err);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic [15:0] r1s[4];
        logic [2:0]  rvs[4];
        logic [15:0] r4[3];
        logic [2:0]  v4[3];
        bit          seen;

        reset = 1'b1; start = 1'b0; k = 4'd0; s = 4'd0; pad = 4'd0; in_width = '0; in_height = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        // k=3 s=1 pad=1 100x4: two segments of two reads per row
        r1s = '{16'hFFFF, 16'd0, 16'd1, 16'd2};
        rvs = '{3'b110, 3'b111, 3'b111, 3'b011};
        for (int r = 0; r < 4; r++) begin
            push_fill(16'd0,  16'd2,  16'd33, 4'd1, 4'd0, 4'd0, r1s[r], rvs[r]);
            push_fill(16'd32, 16'd34, 16'd65, 4'd1, 4'd0, 4'd0, r1s[r], rvs[r]);
            push_shift(2);
            push_fill(16'd62, 16'd3,  16'd34, 4'd0, 4'd2, 4'd1, r1s[r], rvs[r]);
            push_fill(16'd94, 16'd35, 16'd40, 4'd0, 4'd2, 4'd1, r1s[r], rvs[r]);
            push_shift(2);
        end
        push_kind(3, 0);
        pulse_start(4'd3, 4'd1, 4'd1, 16'd100, 16'd4);
        wait_done(1000);

        // k=1 s=1 pad=0 20x2: single read, coincident pulses
        push_fill(16'd0, 16'd1, 16'd20, 4'd0, 4'd0, 4'd0, 16'd0, 3'b001); push_shift(0);
        push_fill(16'd0, 16'd1, 16'd20, 4'd0, 4'd0, 4'd0, 16'd1, 3'b001); push_shift(0);
        push_kind(3, 0);
        pulse_start(4'd1, 4'd1, 4'd0, 16'd20, 16'd2);
        wait_done(500);

        // Delayed ack, k=3 pad=0 40x3: two reads held stable while stalled
        ack_mode = 1;
        push_fill(16'd0,  16'd1,  16'd32, 4'd0, 4'd0, 4'd0, 16'd0, 3'b111);
        push_fill(16'd32, 16'd33, 16'd40, 4'd0, 4'd0, 4'd0, 16'd0, 3'b111);
        push_shift(2);
        push_kind(3, 0);
        pulse_start(4'd3, 4'd1, 4'd0, 16'd40, 16'd3);
        wait_done(500);
        ack_mode = 0;

        // k=3 s=2 pad=1 10x5: Hout=3, last row partially off the bottom
        r4 = '{16'hFFFF, 16'd1, 16'd3};
        v4 = '{3'b110, 3'b111, 3'b011};
        for (int r = 0; r < 3; r++) begin
            push_fill(16'd0, 16'd2, 16'd11, 4'd1, 4'd0, 4'd1, r4[r], v4[r]);
            push_shift(2);
        end
        push_kind(3, 0);
        pulse_start(4'd3, 4'd2, 4'd1, 16'd10, 16'd5);
        wait_done(500);

        // Illegal configs, then a legal start clears the error
        pulse_start(4'd2, 4'd1, 4'd0, 16'd20, 16'd2);
        @(negedge clk);
        check_bit("cfg_err_k2", cfg_err, 1'b1);
        check_bit("busy_k2", busy, 1'b0);
        pulse_start(4'd3, 4'd1, 4'd0, 16'd20, 16'd2);
        @(negedge clk);
        check_bit("cfg_err_short", cfg_err, 1'b1);
        push_fill(16'd0, 16'd1, 16'd20, 4'd0, 4'd0, 4'd0, 16'd0, 3'b001); push_shift(0);
        push_fill(16'd0, 16'd1, 16'd20, 4'd0, 4'd0, 4'd0, 16'd1, 3'b001); push_shift(0);
        push_kind(3, 0);
        pulse_start(4'd1, 4'd1, 4'd0, 16'd20, 16'd2);
        check_bit("cfg_err_cleared", cfg_err, 1'b0);
        wait_done(500);

        // Reset during shift cycle 1 aborts; restart runs from oy=0
        push_fill(16'd0, 16'd2, 16'd21, 4'd1, 4'd0, 4'd1, 16'hFFFF, 3'b110);
        push_kind(1, 0);
        pulse_start(4'd3, 4'd1, 4'd1, 16'd20, 16'd2);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (conv_min_pixels_add_end) seen = 1;
        end
        check_bit("shift_reached", seen, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort_state");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_bit("no_done_after_abort", done, 1'b0);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_events: got %0d pending, expected 0", q.size());
        end
        q.delete();
        push_fill(16'd0, 16'd2, 16'd21, 4'd1, 4'd0, 4'd1, 16'hFFFF, 3'b110); push_shift(2);
        push_fill(16'd0, 16'd2, 16'd21, 4'd1, 4'd0, 4'd1, 16'd0, 3'b011);    push_shift(2);
        push_kind(3, 0);
        pulse_start(4'd3, 4'd1, 4'd1, 16'd20, 16'd2);
        wait_done(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/row_fill_sequencer.md
Name: row_fill_sequencer

Overview:
Controller that drives the three-row shift-register window (70 regs x 8b per row) feeding the conv PE array. For one input-feature-map tile it walks output rows and column segments, and issues 32-pixel fill requests to the row buffer. For each request it supplies the fill geometry: west_pad, slab_num, east_pad, reg_start_idx and reg_end_idx. It then sequences the k-cycle shift/accumulate phase with the conv_min_pixels_add_end and conv_pixels_add_end pulses.

Parameters:
SHIFT_REGS_NUM, 70, shift registers per row in the window.
PIXELS_IN_ROW, 32, pixels delivered per buffer read.
SEG_CAP, 64, max fresh pixels loaded per segment (2 reads).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; latches config, begins tile
k  in  4  kernel size; only 1 or 3 legal
s  in  4  stride, 1..2
pad  in  4  zero pad, 0..1
in_width  in  16  input row width in pixels, 1..4095
in_height  in  16  input rows, 1..4095
rd_req  out  1  buffer read request
rd_ack  in  1  buffer has driven row*_pixels_32 / row*_slab_2 this cycle
rd_col  out  16  first input column of the 32-pixel read
row1_idx, row2_idx, row3_idx  out  16 each  input rows for window rows 1..3
row_valid  out  3  bit i=1 if row(i+1)_idx in [0,in_height-1]; buffer returns zeros otherwise
west_pad, slab_num, east_pad  out  4 each  fill geometry
reg_start_idx, reg_end_idx  out  16 each  1-based window positions for the current read
fill_en  out  1  = rd_req & rd_ack; window captures fill this cycle
conv_min_pixels_add_end  out  1  pulse: fill of segment complete, shift phase begins
conv_pixels_add_end  out  1  pulse: last shift cycle of segment
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after last segment of last output row
cfg_err  out  1  sticky until next legal start

Behaviour:
- Reset: state IDLE; all outputs 0 (row idx 0, row_valid 0, busy 0, done 0, cfg_err 0).
- start in IDLE: latch config. If k not in {1,3}, or s=0, or in_width=0, or in_height=0, or pad>1: set cfg_err, stay IDLE. Else clear cfg_err and go to ROW. start is ignored while busy.
- Hout = (in_height + 2*pad - k)/s + 1, computed in 17-bit unsigned math. If in_height + 2*pad < k, raise cfg_err.
- ROW (1 cycle): oy counter sets row1_idx = oy*s - pad (16-bit wrap; -1 = 0xFFFF), row2 = row1+1, row3 = row1+2.
  - row_valid per row: idx<in_height as unsigned compare, so 0xFFFF is invalid.
  - If k=1, row2/row3 valid bits are forced 0.
  - col=0, seg=0; go to FILL.
- FILL: per segment, P = min(SEG_CAP, in_width - col).
  - west_pad = pad if seg=0, else 0.
  - slab_num = 0 if seg=0, else k-1.
  - east_pad = pad if col+P = in_width, else 0.
  - Read 0: rd_col = col, reg_start_idx = 1 + west_pad + slab_num, reg_end_idx = reg_start_idx + min(32,P) - 1.
  - Read 1 (only if P>32): rd_col = col+32, reg_start = previous end + 1, reg_end = start + (P-32) - 1.
  - rd_req held high with all geometry stable until rd_ack; rd_ack with rd_req low is ignored. Next read is issued the cycle after ack.
  - Invariant: reg_end_idx + east_pad <= SHIFT_REGS_NUM.
- After the final ack, go to SHIFT. conv_min_pixels_add_end pulses on the first SHIFT cycle.
- SHIFT: lasts exactly k cycles, counted 0..k-1. conv_pixels_add_end pulses on cycle k-1; for k=1 both pulses occur in the same cycle. Geometry outputs hold their last values.
- After SHIFT:
  - If col+P < in_width: col <= col+P-(k-1), seg+1, go to FILL.
  - Else, if oy+1 < Hout: oy+1, go to ROW.
  - Else go to DONE.
- DONE: pulse done for 1 cycle, busy low, return to IDLE.
- Reset asserted in any state aborts immediately; next cycle state is IDLE with reset values and no pulse emitted.

Test Plan:
1. k=3,s=1,pad=1,in_width=100,in_height=4, rd_ack tied 1 -> seg0 reads: (col0,start2,end33), (col32,start34,end65), west1 slab0 east0. seg1 reads: (col62,start3,end34), (col94,start35,end40), east1. Hout=4; oy0 rows FFFF/0/1, row_valid=3'b110. done after 4 rows.
2. k=1,s=1,pad=0,in_width=20,in_height=2 -> one read per row, start1, end20. conv_min_pixels_add_end and conv_pixels_add_end coincide. SHIFT lasts 1 cycle; row_valid=3'b001.
3. rd_ack delayed 5 cycles per read -> rd_req, rd_col, reg_start_idx and reg_end_idx stable throughout the wait; exactly one fill_en per read.
4. k=3,s=2,pad=1,in_height=5 -> Hout=3; row1_idx sequence FFFF, 1, 3; the last row's row3=5 gives row_valid=3'b011.
5. start with k=2 -> cfg_err=1, busy stays 0. A subsequent legal start clears cfg_err.
6. Reset asserted during SHIFT cycle 1 -> next cycle IDLE, all outputs 0, no done pulse. A new start runs cleanly from oy=0.
